// File: rtl/dyn_pkg.sv
// Shared dynamic-scheduling definitions used by the CDB producer, the issue queue and the
// future reorder buffer.
//   clog2_min1 : pointer/index width helper that never returns 0
//   CDB_*      : default bus geometry (tag space derived from issue-queue depth)
//   cdb_t      : one CDB beat as seen by consumers (valid, tag, data)
package dyn_pkg;

  // Width of an index into n entries, at least one bit so degenerate sizes still elaborate.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CDB_DATA_WIDTH = 32;
  localparam int unsigned CDB_DEPTH      = 16;
  localparam int unsigned CDB_ID_WIDTH   = $clog2(CDB_DEPTH);

  typedef struct packed {
    logic                      valid;
    logic [CDB_ID_WIDTH-1:0]   tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-execution-unit result buffer in front of the CDB arbiter.
//   clk, resetn : clock, asynchronous active-low reset
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : drop the head entry (ignored when empty)
//   flush_i     : synchronous clear, wins over push and pop
//   wdata_i     : entry to store ({tag, data})
//   count_o     : occupancy 0..BUF_DEPTH
//   head_o      : oldest entry, valid when count_o != 0
//   not_full_o  : registered-state ready, independent of a same-cycle pop
module cdb_fu_fifo
  import dyn_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W    = clog2_min1(BUF_DEPTH),
  localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             not_full_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign not_full_o = (count_q != CNT_W'(BUF_DEPTH));
  assign push_ok    = push_i & not_full_o;
  assign pop_ok     = pop_i & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = ptr_inc(wptr_q);
      if (pop_ok)  rptr_d = ptr_inc(rptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus producer: buffers completed results from NUM_FU execution units and
// broadcasts at most one per cycle, chosen round-robin so no unit starves.
//   clk, resetn : clock, asynchronous active-low reset
//   fu_valid_i  : unit i presents a result (held until accepted)
//   fu_tag_i    : unit i tag  at [i*ID_WIDTH +: ID_WIDTH]
//   fu_data_i   : unit i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   fu_ready_o  : unit i buffer has room
//   flush_i     : discard every pending result
//   cdb_valid   : broadcast valid for exactly one cycle per result
//   cdb_tag     : broadcast tag
//   cdb_data    : broadcast data
//   cdb_grant   : one-hot source unit of the current broadcast, 0 when idle
module cdb_arbiter
  import dyn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ID_WIDTH   = $clog2(DEPTH),
  parameter int unsigned NUM_FU     = 4,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_FU-1:0]            fu_valid_i,
  input  logic [NUM_FU*ID_WIDTH-1:0]   fu_tag_i,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data_i,
  output logic [NUM_FU-1:0]            fu_ready_o,
  input  logic                         flush_i,
  output logic                         cdb_valid,
  output logic [ID_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [NUM_FU-1:0]            cdb_grant
);

  localparam int unsigned ENTRY_W = ID_WIDTH + DATA_WIDTH;
  localparam int unsigned RR_W    = clog2_min1(NUM_FU);
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);

  logic [CNT_W-1:0]   count [NUM_FU];
  logic [ENTRY_W-1:0] head  [NUM_FU];
  logic [NUM_FU-1:0]  req, push, pop, not_full;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    assign push[i] = fu_valid_i[i];
    assign req[i]  = (count[i] != '0);

    cdb_fu_fifo #(
      .WIDTH     (ENTRY_W),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push_i     (push[i]),
      .pop_i      (pop[i]),
      .flush_i    (flush_i),
      .wdata_i    ({fu_tag_i[i*ID_WIDTH +: ID_WIDTH], fu_data_i[i*DATA_WIDTH +: DATA_WIDTH]}),
      .count_o    (count[i]),
      .head_o     (head[i]),
      .not_full_o (not_full[i])
    );
  end

  assign fu_ready_o = not_full;

  // Round-robin pick over registered occupancy only: no input-to-CDB bypass.
  logic              win_found;
  logic [RR_W-1:0]   win_idx;
  logic [NUM_FU-1:0] win_onehot;
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              valid_d;
  logic [ID_WIDTH-1:0]   tag_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [NUM_FU-1:0]     grant_d;
  logic [ENTRY_W-1:0]    win_head;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_FU;
      if (!win_found && req[RR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = RR_W'(cand);
      end
    end
  end

  assign win_onehot = NUM_FU'(1) << win_idx;
  assign win_head   = head[win_idx];
  assign pop        = (win_found && !flush_i) ? win_onehot : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    valid_d  = 1'b0;
    grant_d  = '0;
    tag_d    = cdb_tag;
    data_d   = cdb_data;
    // Flush drops the pick; rr_ptr is kept so fairness survives the flush.
    if (!flush_i && win_found) begin
      valid_d  = 1'b1;
      grant_d  = win_onehot;
      tag_d    = win_head[ENTRY_W-1 -: ID_WIDTH];
      data_d   = win_head[DATA_WIDTH-1:0];
      rr_ptr_d = (win_idx == RR_W'(NUM_FU - 1)) ? '0 : win_idx + RR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q  <= '0;
      cdb_valid <= 1'b0;
      cdb_grant <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cdb_valid <= valid_d;
      cdb_grant <= grant_d;
      cdb_tag   <= tag_d;
      cdb_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int NFU = 4;
  localparam int IW  = 4;
  localparam int DW  = 32;
  localparam int BD  = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NFU-1:0]  fu_valid = '0;
  logic [NFU*IW-1:0] fu_tag = '0;
  logic [NFU*DW-1:0] fu_data = '0;
  logic [NFU-1:0]  fu_ready;
  logic            flush = 1'b0;
  logic            cdb_valid;
  logic [IW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [NFU-1:0]  cdb_grant;

  cdb_arbiter #(
    .DATA_WIDTH (DW),
    .DEPTH      (16),
    .ID_WIDTH   (IW),
    .NUM_FU     (NFU),
    .BUF_DEPTH  (BD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .fu_valid_i (fu_valid),
    .fu_tag_i   (fu_tag),
    .fu_data_i  (fu_data),
    .fu_ready_o (fu_ready),
    .flush_i    (flush),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .cdb_grant  (cdb_grant)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // ---------------- behavioural model: per-unit queues + round-robin pointer --------------
  logic [IW-1:0] mq_tag  [NFU][$];
  logic [DW-1:0] mq_data [NFU][$];
  int            m_rr    = 0;
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_tag   = '0;
  logic [DW-1:0] m_data  = '0;
  logic [NFU-1:0] m_grant = '0;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      for (int i = 0; i < NFU; i++) begin
        mq_tag[i].delete();
        mq_data[i].delete();
      end
      m_rr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_grant = '0;
    end else if (flush) begin
      for (int i = 0; i < NFU; i++) begin
        mq_tag[i].delete();
        mq_data[i].delete();
      end
      m_valid = 0; m_grant = '0;
    end else begin
      bit rdy [NFU];
      int w;
      for (int i = 0; i < NFU; i++) rdy[i] = (mq_tag[i].size() < BD);
      w = -1;
      for (int k = 0; k < NFU; k++) begin
        int c;
        c = (m_rr + k) % NFU;
        if (w < 0 && mq_tag[c].size() > 0) w = c;
      end
      if (w >= 0) begin
        m_valid = 1;
        m_grant = '0;
        m_grant[w] = 1'b1;
        m_tag   = mq_tag[w].pop_front();
        m_data  = mq_data[w].pop_front();
        m_rr    = (w + 1) % NFU;
      end else begin
        m_valid = 0;
        m_grant = '0;
      end
      for (int i = 0; i < NFU; i++) begin
        if (fu_valid[i] && rdy[i]) begin
          mq_tag[i].push_back(fu_tag[i*IW +: IW]);
          mq_data[i].push_back(fu_data[i*DW +: DW]);
        end
      end
    end
  end

  // ---------------- per-cycle compare + broadcast log ---------------------------------------
  typedef struct {
    logic [NFU-1:0] grant;
    logic [IW-1:0]  tag;
  } bc_t;
  bc_t bcast[$];

  initial forever begin
    logic [NFU-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NFU; i++) exp_rdy[i] = (mq_tag[i].size() < BD);
    check("cyc_valid", 64'(cdb_valid), 64'(m_valid));
    check("cyc_grant", 64'(cdb_grant), 64'(m_grant));
    check("cyc_tag",   64'(cdb_tag),   64'(m_tag));
    check("cyc_data",  64'(cdb_data),  64'(m_data));
    check("cyc_ready", 64'(fu_ready),  64'(exp_rdy));
    if (cdb_valid) bcast.push_back('{grant: cdb_grant, tag: cdb_tag});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ---------------------------------------------------------
  task automatic set_fu(input int i, input logic v, input logic [IW-1:0] t,
                        input logic [DW-1:0] d);
    fu_valid[i] = v;
    fu_tag[i*IW +: IW] = t;
    fu_data[i*DW +: DW] = d;
  endtask

  task automatic clear_fu();
    fu_valid = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 resetn = 1'b0;
    @(negedge clk); #2 resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [IW-1:0] u1_tags[$];
    bit accepted;

    tick(2); #2 resetn = 1'b1;
    tick(1);
    check("reset_ready", 64'(fu_ready), 64'hF);
    check("reset_valid", 64'(cdb_valid), 64'h0);

    // 1: reset mid-stream, three results still pending
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, IW'(i + 1), DW'(32'h100 + i));
    tick(1); clear_fu();
    tick(1);
    #2 resetn = 1'b0;
    #1;
    check("t1_async_valid", 64'(cdb_valid), 64'h0);
    check("t1_async_grant", 64'(cdb_grant), 64'h0);
    check("t1_async_ready", 64'(fu_ready), 64'hF);
    @(negedge clk); #2 resetn = 1'b1;
    bcast.delete();
    tick(6);
    check("t1_no_bcast", 64'(bcast.size()), 64'h0);

    // 2: single result latency
    set_fu(0, 1'b1, 4'd3, 32'hDEADBEEF);
    tick(1); clear_fu();
    check("t2_not_yet", 64'(cdb_valid), 64'h0);
    tick(1);
    check("t2_valid", 64'(cdb_valid), 64'h1);
    check("t2_tag",   64'(cdb_tag),   64'h3);
    check("t2_data",  64'(cdb_data),  64'hDEADBEEF);
    check("t2_grant", 64'(cdb_grant), 64'h1);
    tick(1);
    check("t2_idle",  64'(cdb_valid), 64'h0);

    // 3: all units push at once from rr_ptr=0
    do_reset();
    bcast.delete();
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, IW'(i + 1), DW'(32'h300 + i));
    tick(1); clear_fu();
    tick(6);
    check("t3_count", 64'(bcast.size()), 64'h4);
    if (bcast.size() == 4) begin
      for (int i = 0; i < NFU; i++) begin
        check("t3_grant", 64'(bcast[i].grant), 64'(4'b0001 << i));
        check("t3_tag",   64'(bcast[i].tag),   64'(i + 1));
      end
    end

    // 4: unit 0 streaming, unit 2 single push must not starve
    bcast.delete();
    set_fu(0, 1'b1, 4'd5, 32'h50);
    tick(1); set_fu(2, 1'b1, 4'd9, 32'h90);
    tick(1); set_fu(2, 1'b0, 4'd9, 32'h90);
    tick(4); clear_fu();
    tick(8);
    check("t4_len", 64'(bcast.size() >= 3), 64'h1);
    if (bcast.size() >= 3) begin
      check("t4_g0",   64'(bcast[0].grant), 64'b0001);
      check("t4_g1",   64'(bcast[1].grant), 64'b0100);
      check("t4_tag9", 64'(bcast[1].tag),   64'h9);
      check("t4_g2",   64'(bcast[2].grant), 64'b0001);
    end

    // 5: unit 1 back-pressured at BUF_DEPTH, third result accepted after first pop
    do_reset();
    bcast.delete();
    set_fu(0, 1'b1, 4'd1, 32'h501); set_fu(1, 1'b1, 4'd11, 32'h511);
    set_fu(2, 1'b1, 4'd7, 32'h521);
    tick(1);
    set_fu(0, 1'b1, 4'd2, 32'h502); set_fu(1, 1'b1, 4'd12, 32'h512);
    set_fu(2, 1'b1, 4'd8, 32'h522);
    tick(1);
    set_fu(0, 1'b0, 4'd0, 32'h0); set_fu(2, 1'b0, 4'd0, 32'h0);
    set_fu(1, 1'b1, 4'd13, 32'h513);
    check("t5_u1_full", 64'(fu_ready[1]), 64'h0);
    accepted = 0;
    for (int c = 0; c < 10 && !accepted; c++) begin
      if (fu_ready[1]) accepted = 1;
      tick(1);
    end
    clear_fu();
    check("t5_accepted", 64'(accepted), 64'h1);
    tick(8);
    check("t5_total", 64'(bcast.size()), 64'h7);
    foreach (bcast[i]) if (bcast[i].grant == 4'b0010) u1_tags.push_back(bcast[i].tag);
    check("t5_u1_count", 64'(u1_tags.size()), 64'h3);
    if (u1_tags.size() == 3) begin
      check("t5_u1_t0", 64'(u1_tags[0]), 64'd11);
      check("t5_u1_t1", 64'(u1_tags[1]), 64'd12);
      check("t5_u1_t2", 64'(u1_tags[2]), 64'd13);
    end

    // 6: flush drops pending and same-edge pushes, keeps rr_ptr (moved to 2 first)
    do_reset();
    set_fu(1, 1'b1, 4'd15, 32'h615);
    tick(1); clear_fu();
    tick(2);
    bcast.delete();
    set_fu(3, 1'b1, 4'd7, 32'h70);
    tick(1);
    set_fu(3, 1'b1, 4'd8, 32'h80); set_fu(0, 1'b1, 4'd6, 32'h60);
    flush = 1'b1;
    tick(1);
    clear_fu(); flush = 1'b0;
    check("t6_valid", 64'(cdb_valid), 64'h0);
    check("t6_ready", 64'(fu_ready),  64'hF);
    tick(4);
    check("t6_no_bcast", 64'(bcast.size()), 64'h0);
    for (int i = 0; i < NFU; i++) set_fu(i, 1'b1, IW'(i + 1), DW'(32'h600 + i));
    tick(1); clear_fu();
    tick(6);
    check("t6_count", 64'(bcast.size()), 64'h4);
    if (bcast.size() == 4) begin
      check("t6_g0", 64'(bcast[0].grant), 64'b0100);
      check("t6_g1", 64'(bcast[1].grant), 64'b1000);
      check("t6_g2", 64'(bcast[2].grant), 64'b0001);
      check("t6_g3", 64'(bcast[3].grant), 64'b0010);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
